uart_tx_wb: RTL and testbench

Wishbone-slave UART transmitter that hangs off the MCU core's memory-mapped register host port, downstream of the machine-timer/register decoder. It consumes the separate read and write Wishbone channels and decodes three word registers: DATA, STATUS and BAUD. Bytes written to DATA are queued in a FIFO and shifted out as 8N1 frames, LSB first, on `txd`.

---
 rtl/uart_tx_wb.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone-slave 8N1 UART transmitter with TX FIFO.
// Registers: DATA (push), STATUS (flags/count), BAUD (clocks per bit).
module uart_tx_wb #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned BASE_ADDR    = 'h10,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DEFAULT = 16'd868
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 WB_RD_STB_I,
    input  logic [ADDR_BITS-1:0] WB_RD_ADR_I,
    output logic [31:0]          WB_RD_DAT_O,
    output logic                 WB_RD_ACK_O,
    input  logic                 WB_WR_WE_I,
    input  logic [3:0]           WB_WR_SEL_I,
    input  logic [ADDR_BITS-1:0] WB_WR_ADR_I,
    input  logic [31:0]          WB_WR_DAT_I,
    output logic                 WB_WR_ACK_O,
    output logic                 txd,
    output logic                 tx_idle_irq
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   baud_q, baud_d;
    logic          ovf_q, ovf_d;
    logic [4:0]    count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic          rd_ack_q, rd_ack_d;
    logic          wr_ack_q, wr_ack_d;
    logic [31:0]   rd_dat_q, rd_dat_d;

    logic [ADDR_BITS-1:0] rd_off, wr_off;
    logic        rd_hit, wr_hit, stat_rd;
    logic        push, push_ok, pop;
    logic        full, empty, bit_end;
    logic [7:0]  head;
    logic [15:0] baud_wr;

    assign rd_off  = WB_RD_ADR_I - BASE;
    assign wr_off  = WB_WR_ADR_I - BASE;
    assign rd_hit  = WB_RD_STB_I && (rd_off < ADDR_BITS'(3));
    assign wr_hit  = WB_WR_WE_I && (wr_off < ADDR_BITS'(3));
    assign stat_rd = rd_hit && (rd_off == ADDR_BITS'(1));
    assign push    = wr_hit && (wr_off == '0) && WB_WR_SEL_I[0];
    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == 5'd0);
    assign bit_end = (cnt_q == 16'd0);
    assign head    = mem_q[rd_ptr_q];

    assign WB_RD_DAT_O = rd_dat_q;
    assign WB_RD_ACK_O = rd_ack_q;
    assign WB_WR_ACK_O = wr_ack_q;
    assign txd         = txd_q;
    assign tx_idle_irq = irq_q;

    // Next-state: transmit FSM, FIFO, registers and bus responses.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        baud_d   = baud_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        pop      = 1'b0;
        push_ok  = 1'b0;
        baud_wr  = baud_q;

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    cnt_d   = baud_q - 16'd1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = baud_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = baud_q - 16'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        cnt_d   = baud_q - 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase

        // A full FIFO still takes a push when the head leaves this cycle.
        push_ok = push && (!full || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = WB_WR_DAT_I[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + 5'(push_ok) - 5'(pop);

        if (stat_rd) ovf_d = 1'b0;
        if (push && !push_ok) ovf_d = 1'b1;

        if (wr_hit && (wr_off == ADDR_BITS'(2))) begin
            if (WB_WR_SEL_I[0]) baud_wr[7:0]  = WB_WR_DAT_I[7:0];
            if (WB_WR_SEL_I[1]) baud_wr[15:8] = WB_WR_DAT_I[15:8];
            baud_d = (baud_wr < 16'd2) ? 16'd2 : baud_wr;
        end

        rd_ack_d = rd_hit;
        wr_ack_d = wr_hit;
        rd_dat_d = 32'd0;
        if (stat_rd) begin
            rd_dat_d = {23'd0, count_q, ovf_q, empty, full,
                        state_q != S_IDLE};
        end else if (rd_hit && (rd_off == ADDR_BITS'(2))) begin
            rd_dat_d = {16'd0, baud_q};
        end

        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = (state_d == S_IDLE) && empty;

        if (sync_reset) begin
            state_d  = S_IDLE;
            shift_d  = 8'd0;
            bit_d    = 3'd0;
            cnt_d    = 16'd0;
            baud_d   = BAUD_DEFAULT;
            ovf_d    = 1'b0;
            count_d  = 5'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            txd_d    = 1'b1;
            irq_d    = 1'b1;
            rd_ack_d = 1'b0;
            wr_ack_d = 1'b0;
            rd_dat_d = 32'd0;
        end
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'd0;
            bit_q    <= 3'd0;
            cnt_q    <= 16'd0;
            baud_q   <= BAUD_DEFAULT;
            ovf_q    <= 1'b0;
            count_q  <= 5'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b1;
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            rd_dat_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            baud_q   <= baud_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            rd_ack_q <= rd_ack_d;
            wr_ack_q <= wr_ack_d;
            rd_dat_q <= rd_dat_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_wb.sv
// tb_uart_tx_wb: directed + randomized bench for uart_tx_wb.
// Frames are decoded by a bit-level receiver and matched to a byte queue.
module tb_uart_tx_wb;
    localparam logic [7:0] BASE  = 8'h10;
    localparam int         DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        WB_RD_STB_I = 1'b0;
    logic [7:0]  WB_RD_ADR_I = 8'h0;
    logic [31:0] WB_RD_DAT_O;
    logic        WB_RD_ACK_O;
    logic        WB_WR_WE_I = 1'b0;
    logic [3:0]  WB_WR_SEL_I = 4'h0;
    logic [7:0]  WB_WR_ADR_I = 8'h0;
    logic [31:0] WB_WR_DAT_I = 32'h0;
    logic        WB_WR_ACK_O;
    logic        txd;
    logic        tx_idle_irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // receiver state
    logic       mon_en = 1'b0;
    int         mon_baud = 2;
    logic [7:0] mon_bits;
    logic       mon_stop;
    int         mon_st;
    logic [8:0] rx_q[$];
    int         st_q[$];
    logic [7:0] exp_q[$];

    uart_tx_wb dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .WB_RD_STB_I(WB_RD_STB_I), .WB_RD_ADR_I(WB_RD_ADR_I),
        .WB_RD_DAT_O(WB_RD_DAT_O), .WB_RD_ACK_O(WB_RD_ACK_O),
        .WB_WR_WE_I(WB_WR_WE_I), .WB_WR_SEL_I(WB_WR_SEL_I),
        .WB_WR_ADR_I(WB_WR_ADR_I), .WB_WR_DAT_I(WB_WR_DAT_I),
        .WB_WR_ACK_O(WB_WR_ACK_O), .txd(txd), .tx_idle_irq(tx_idle_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples the first cycle of every bit after a falling edge.
    always begin
        @(posedge clk); #1;
        if (mon_en && txd === 1'b0) begin
            mon_st = cyc;
            for (int k = 0; k < 8; k++) begin
                repeat (mon_baud) @(posedge clk);
                #1;
                mon_bits[k] = txd;
            end
            repeat (mon_baud) @(posedge clk);
            #1;
            mon_stop = txd;
            rx_q.push_back({mon_stop, mon_bits});
            st_q.push_back(mon_st);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic [31:0] status_word(input int busy,
                                                input int cnt,
                                                input int ovf);
        logic [31:0] s;
        s = 32'd0;
        s[0] = (busy != 0);
        s[1] = (cnt == DEPTH);
        s[2] = (cnt == 0);
        s[3] = (ovf != 0);
        s[8:4] = 5'(cnt);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input string tag);
        WB_WR_WE_I  = 1'b1;
        WB_WR_ADR_I = adr;
        WB_WR_DAT_I = dat;
        WB_WR_SEL_I = sel;
        tick();
        WB_WR_WE_I  = 1'b0;
        chk(tag, 32'(WB_WR_ACK_O), 32'd1);
    endtask

    task automatic wb_rd(input logic [7:0] adr, output logic [31:0] d);
        WB_RD_STB_I = 1'b1;
        WB_RD_ADR_I = adr;
        tick();
        WB_RD_STB_I = 1'b0;
        chk("rd_ack", 32'(WB_RD_ACK_O), 32'd1);
        d = WB_RD_DAT_O;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          w0, t, acc, dropped, n, ack_seen;
        logic [7:0]  first;

        // reset state
        repeat (3) tick();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(tx_idle_irq), 32'd1);
        chk("rst_rd_ack", 32'(WB_RD_ACK_O), 32'd0);
        chk("rst_wr_ack", 32'(WB_WR_ACK_O), 32'd0);
        chk("rst_rd_dat", WB_RD_DAT_O, 32'd0);
        reset_n = 1'b1;
        tick();

        wb_rd(BASE + 8'd1, d);
        chk("status_reset", d, status_word(0, 0, 0));
        tick();
        chk("rd_ack_single", 32'(WB_RD_ACK_O), 32'd0);
        chk("rd_dat_idle", WB_RD_DAT_O, 32'd0);
        chk("idle_txd", 32'(txd), 32'd1);
        chk("idle_irq", 32'(tx_idle_irq), 32'd1);

        // DATA write without byte lane 0 must not push
        wb_wr(BASE, 32'hFFFF_FF5A, 4'b1110, "nosel_ack");
        repeat (3) tick();
        wb_rd(BASE + 8'd1, d);
        chk("nosel_status", d, status_word(0, 0, 0));
        chk("nosel_txd", 32'(txd), 32'd1);
        wb_rd(BASE, d);
        chk("data_rd_zero", d, 32'd0);

        // single frame 0xA5 at 4 clocks/bit
        wb_wr(BASE + 8'd2, 32'd4, 4'b0011, "baud4_ack");
        wb_wr(BASE, 32'h0000_00A5, 4'b0001, "a5_ack");
        chk("a5_txd_t1", 32'(txd), 32'd1);
        chk("a5_irq_t1", 32'(tx_idle_irq), 32'd1);
        tick();
        chk("a5_irq_t2", 32'(tx_idle_irq), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 0)
                chk($sformatf("a5_bit%0d", c / 4), 32'(txd),
                    32'(frame_bit(8'hA5, c / 4)));
            if (c == 39) chk("a5_irq_last", 32'(tx_idle_irq), 32'd0);
            tick();
        end
        chk("a5_irq_back", 32'(tx_idle_irq), 32'd1);
        chk("a5_txd_idle", 32'(txd), 32'd1);

        // 9 random bytes back-to-back at 2 clocks/bit
        wb_wr(BASE + 8'd2, 32'd2, 4'b0011, "baud2_ack");
        mon_baud = 2;
        rx_q.delete();
        st_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        w0 = cyc;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wb_wr(BASE, {24'h0, b}, 4'($urandom) | 4'b0001, "burst_ack");
        end
        for (int i = 0; i < 400 && rx_q.size() < 9; i++) tick();
        repeat (25) tick();
        mon_en = 1'b0;
        chk("burst_frames", 32'(rx_q.size()), 32'd9);
        n = (rx_q.size() < 9) ? rx_q.size() : 9;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("burst_byte%0d", i), 32'(rx_q[i]),
                32'({1'b1, exp_q[i]}));
            if (i == 0)
                chk("burst_first_start", 32'(st_q[0]), 32'(w0 + 2));
            else
                chk($sformatf("burst_gap%0d", i),
                    32'(st_q[i] - st_q[i-1]), 32'd20);
        end
        wb_rd(BASE + 8'd1, d);
        chk("burst_status", d, status_word(0, 0, 0));

        // BAUD register byte lanes and clamp
        wb_wr(BASE + 8'd2, 32'd0, 4'b0011, "baud0_ack");
        wb_rd(BASE + 8'd2, d);
        chk("baud0_clamp", d, 32'd2);
        wb_wr(BASE + 8'd2, 32'd1, 4'b1111, "baud1_ack");
        wb_rd(BASE + 8'd2, d);
        chk("baud1_clamp", d, 32'd2);
        wb_wr(BASE + 8'd2, 32'hDEAD_1234, 4'b1111, "baud_full_ack");
        wb_wr(BASE + 8'd2, 32'hFFFF_FF56, 4'b0001, "baud_lo_ack");
        wb_rd(BASE + 8'd2, d);
        chk("baud_lo_lane", d, 32'h0000_1256);
        wb_wr(BASE + 8'd2, 32'h0000_9900, 4'b0010, "baud_hi_ack");
        wb_rd(BASE + 8'd2, d);
        chk("baud_hi_lane", d, 32'h0000_9956);
        wb_wr(BASE + 8'd1, 32'hFFFF_FFFF, 4'b1111, "status_wr_ack");
        wb_rd(BASE + 8'd1, d);
        chk("status_wr_noeffect", d, status_word(0, 0, 0));

        // out-of-range requests
        WB_RD_STB_I = 1'b1;
        WB_RD_ADR_I = BASE + 8'd3;
        WB_WR_WE_I  = 1'b1;
        WB_WR_ADR_I = BASE - 8'd1;
        WB_WR_SEL_I = 4'b1111;
        WB_WR_DAT_I = 32'h0000_0077;
        ack_seen = 0;
        tick();
        WB_RD_STB_I = 1'b0;
        WB_WR_WE_I  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (WB_RD_ACK_O !== 1'b0 || WB_WR_ACK_O !== 1'b0) ack_seen++;
            if (WB_RD_DAT_O !== 32'd0) ack_seen++;
            tick();
        end
        chk("oor_no_ack", 32'(ack_seen), 32'd0);
        chk("oor_txd", 32'(txd), 32'd1);

        // overflow at 1000 clocks/bit
        wb_wr(BASE + 8'd2, 32'd1000, 4'b0011, "baud1000_ack");
        w0 = cyc;
        first = 8'h00;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (i == 0) first = b;
            wb_wr(BASE, {24'h0, b}, 4'b0001, "ovf_push_ack");
        end
        acc = (10 - 1 > DEPTH) ? DEPTH : 10 - 1;
        dropped = 10 - 1 - acc;
        wb_rd(BASE + 8'd1, d);
        chk("ovf_status", d, status_word(1, acc, dropped));
        wb_rd(BASE + 8'd1, d);
        chk("ovf_cleared", d, status_word(1, acc, 0));

        // sync reset in the middle of data bit 0
        t = w0 + 2 + 1000 + 500;
        while (cyc < t) tick();
        chk("mid_bit0", 32'(txd), 32'(frame_bit(first, 1)));
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("srst_txd", 32'(txd), 32'd1);
        chk("srst_irq", 32'(tx_idle_irq), 32'd1);
        wb_rd(BASE + 8'd1, d);
        chk("srst_status", d, status_word(0, 0, 0));
        wb_rd(BASE + 8'd2, d);
        chk("srst_baud", d, 32'd868);
        repeat (5) tick();
        chk("srst_txd_hold", 32'(txd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
